// File: rtl/timer_pkg.sv
// Shared types and constants for the 3-digit BCD countdown timer.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   DIGITS  = 3;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: next value on load (clamped to 9) or borrow-driven decrement.
// Purely combinational; the owning block holds the digit register and chains borrow_out to the next digit.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       enable,
  input  logic       borrow_in,
  input  logic [3:0] value,
  output logic [3:0] value_nxt,
  output logic       borrow_out
);

  logic dec;

  assign dec        = enable && borrow_in;
  assign borrow_out = dec && (value == 4'd0);

  always_comb begin
    value_nxt = value;
    if (load) begin
      value_nxt = bcd_clamp(load_val);
    end else if (dec) begin
      value_nxt = (value == 4'd0) ? BCD_MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// 3-digit BCD countdown timer with pause/abort; TIMER_WARN_EN adds the blinking low_time output.
// Outputs registered (one cycle after the causing edge); no backpressure, pulses are not held.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int          TICK_DIV   = 31_500_000,
  parameter logic [11:0] WARN_LEVEL = 12'h010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] load_val,
  input  logic        pause,
  input  logic        abort,
  output logic [11:0] digits,
  output logic        running,
  output logic        tick,
  output logic        expired,
  output logic        done
`ifdef TIMER_WARN_EN
  ,
  output logic        low_time
`endif
);

  localparam int PW = $clog2(TICK_DIV);

  timer_state_t  state_d, state_q;
  logic [11:0]   digits_d, digits_q;
  logic [PW-1:0] presc_d, presc_q;
  logic          tick_d, tick_q, expired_d, expired_q;
  logic          running_d, running_q, done_d, done_q;

  logic          load, dec, wrap;
  logic [11:0]   chain_val;
  logic [DIGITS:0] borrow;

  assign wrap      = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign load      = start && !abort;
  assign dec       = wrap && !abort && !start;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .load       (load),
      .load_val   (load_val[4*i +: 4]),
      .enable     (dec),
      .borrow_in  (borrow[i]),
      .value      (digits_q[4*i +: 4]),
      .value_nxt  (chain_val[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      digits_d = '0;
      presc_d  = '0;
    end else if (start) begin
      digits_d = chain_val;
      presc_d  = '0;
      if (chain_val == '0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (wrap) begin
            presc_d  = '0;
            tick_d   = 1'b1;
            // A borrow out of the hundreds digit would mean 000 -> 999; pin at 000 instead.
            digits_d = borrow[DIGITS] ? '0 : chain_val;
            if (digits_d == '0) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else if (pause) begin
              state_d = ST_PAUSE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (pause) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: presc_d = '0;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign expired = expired_q;
  assign done    = done_q;

`ifdef TIMER_WARN_EN
  localparam int HALF = TICK_DIV / 2;

  logic          warn_d, warn_q, low_time_d, low_time_q;
  logic [PW-1:0] blink_d, blink_q;

  // Packed BCD compares in the same order as the decimal values it encodes.
  always_comb begin
    warn_d     = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) && (digits_d <= WARN_LEVEL);
    low_time_d = 1'b0;
    blink_d    = '0;
    if (warn_d) begin
      if (!warn_q) begin
        low_time_d = 1'b1;
      end else if (blink_q == PW'(HALF - 1)) begin
        low_time_d = ~low_time_q;
      end else begin
        low_time_d = low_time_q;
        blink_d    = blink_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warn_q     <= 1'b0;
      low_time_q <= 1'b0;
      blink_q    <= '0;
    end else begin
      warn_q     <= warn_d;
      low_time_q <= low_time_d;
      blink_q    <= blink_d;
    end
  end

  assign low_time = low_time_q;
`endif

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Randomised and directed checks of countdown_timer_ctrl against a decimal-arithmetic reference model.
module tb_countdown_timer_ctrl;

  localparam int          TD = 4;
  localparam logic [11:0] WL = 12'h003;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam logic [11:0] SEQ [3] = '{12'h101, 12'h100, 12'h099};

  logic        clk = 1'b0;
  logic        reset, start, pause, abort;
  logic [11:0] load_val, digits;
  logic        running, tick, expired, done;
`ifdef TIMER_WARN_EN
  logic        low_time;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: remaining time as a plain decimal integer plus a step phase.
  int m_val = 0, m_mode = M_IDLE, m_pre = 0, m_wcnt = 0;
  bit m_tick = 0, m_exp = 0, m_win = 0, m_low = 0;

  countdown_timer_ctrl #(.TICK_DIV(TD), .WARN_LEVEL(WL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .abort    (abort),
    .digits   (digits),
    .running  (running),
    .tick     (tick),
    .expired  (expired),
    .done     (done)
`ifdef TIMER_WARN_EN
    ,
    .low_time (low_time)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int dig(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic int clamp_dec(input logic [11:0] lv);
    return dig(lv[11:8]) * 100 + dig(lv[7:4]) * 10 + dig(lv[3:0]);
  endfunction

  function automatic void model_edge(input bit rst, input bit st, input logic [11:0] lv,
                                     input bit ps, input bit ab);
    m_tick = 0;
    m_exp  = 0;
    if (rst) begin
      m_mode = M_IDLE; m_val = 0; m_pre = 0;
    end else if (ab) begin
      m_mode = M_IDLE; m_val = 0; m_pre = 0;
    end else if (st) begin
      m_val = clamp_dec(lv);
      m_pre = 0;
      if (m_val == 0) begin m_mode = M_DONE; m_exp = 1; end
      else m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (m_pre == TD - 1) begin
        m_pre = 0; m_val = m_val - 1; m_tick = 1;
        if (m_val == 0) begin m_mode = M_DONE; m_exp = 1; end
        else if (ps) m_mode = M_PAUSE;
      end else begin
        m_pre = m_pre + 1;
        if (ps) m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE) begin
      if (!ps) m_mode = M_RUN;
    end
    if ((m_mode == M_RUN || m_mode == M_PAUSE) && m_val <= clamp_dec(WL)) begin
      m_wcnt = m_win ? m_wcnt + 1 : 0;
      m_win  = 1;
      m_low  = ((m_wcnt / (TD / 2)) % 2) == 0;
    end else begin
      m_win = 0;
      m_low = 0;
    end
  endfunction

  function automatic logic [15:0] m_pack();
    return {to_bcd(m_val), m_mode == M_RUN, m_tick, m_exp, m_mode == M_DONE};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(reset, start, load_val, pause, abort);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; pause = 0; abort = 0; load_val = '0;
    step(); step();
    total++;
    if ({digits, running, tick, expired, done} !== 16'h0000) begin
      bad++; $display("FAIL reset_state got=%h want=0000", {digits, running, tick, expired, done});
    end
    reset = 0;
  endtask

  task automatic test_count();
    logic [11:0] want_d;
    load_val = 12'h102; start = 1; step(); start = 0;
    total++;
    if (running !== 1'b1 || digits !== 12'h102) begin
      bad++; $display("FAIL count_load got=%h/%b want=102/1", digits, running);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      want_d = (k < 4) ? 12'h102 : SEQ[k/4-1];
      total++;
      if (digits !== want_d || tick !== (k % 4 == 0)) begin
        bad++; $display("FAIL count_step k=%0d got=%h/%b want=%h/%b", k, digits, tick, want_d, k % 4 == 0);
      end
      total++;
      if ({digits, running, tick, expired, done} !== m_pack()) begin
        bad++; $display("FAIL count_model got=%h want=%h", {digits, running, tick, expired, done}, m_pack());
      end
    end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_expire();
    load_val = 12'h002; start = 1; step(); start = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (expired !== (k == 8)) begin
        bad++; $display("FAIL expire_pulse k=%0d got=%b want=%b", k, expired, k == 8);
      end
    end
    total++;
    if ({digits, done, running} !== {12'h000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL expire_state got=%h/%b/%b want=000/1/0", digits, done, running);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if ({digits, expired, done, running, tick} !== {12'h000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        bad++; $display("FAIL expire_hold k=%0d got=%h/%b/%b/%b/%b", k, digits, expired, done, running, tick);
      end
    end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_pause();
    int seen;
    load_val = 12'h050; start = 1; step(); start = 0;
    step();
    pause = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({digits, tick, running} !== {12'h050, 1'b0, 1'b0}) begin
        bad++; $display("FAIL pause_hold k=%0d got=%h/%b/%b want=050/0/0", k, digits, tick, running);
      end
    end
    pause = 0;
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      step();
      if (tick === 1'b1) seen = k;
    end
    total++;
    if (seen != 3 || digits !== 12'h049) begin
      bad++; $display("FAIL pause_resume got=%0d/%h want=3/049", seen, digits);
    end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_abort_start();
    load_val = 12'h077; start = 1; step(); start = 0;
    step(); step(); step();
    abort = 1; start = 1; load_val = 12'h123; step(); abort = 0; start = 0;
    total++;
    if ({digits, running, tick, done} !== 15'h0) begin
      bad++; $display("FAIL abort_prio got=%h/%b/%b/%b want=000/0/0/0", digits, running, tick, done);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if ({digits, tick, running} !== 14'h0) begin
        bad++; $display("FAIL abort_idle k=%0d got=%h/%b/%b", k, digits, tick, running);
      end
    end
    load_val = 12'h0A5; start = 1; step(); start = 0;
    total++;
    if (digits !== 12'h095 || running !== 1'b1) begin
      bad++; $display("FAIL clamp_load got=%h/%b want=095/1", digits, running);
    end
    abort = 1; step(); abort = 0;
  endtask

  task automatic test_reset_mid();
    load_val = 12'h037; start = 1; step(); start = 0;
    repeat (6) step();
    reset = 1; step(); reset = 0;
    total++;
    if ({digits, running, tick, expired, done} !== 16'h0000) begin
      bad++; $display("FAIL reset_mid got=%h want=0000", {digits, running, tick, expired, done});
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if ({digits, running, expired} !== 14'h0) begin
        bad++; $display("FAIL reset_quiet k=%0d got=%h/%b/%b", k, digits, running, expired);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      r        = $urandom_range(0, 199);
      reset    = (r == 0);
      abort    = (r == 1 || r == 2);
      start    = (r >= 3 && r <= 5);
      load_val = {4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0),
                  4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1)),
                  4'($urandom_range(0, 15))};
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      step();
      total++;
      if ({digits, running, tick, expired, done} !== m_pack()) begin
        bad++; $display("FAIL random n=%0d got=%h want=%h", n, {digits, running, tick, expired, done}, m_pack());
      end
`ifdef TIMER_WARN_EN
      total++;
      if (low_time !== m_low) begin
        bad++; $display("FAIL random_low n=%0d got=%b want=%b", n, low_time, m_low);
      end
`endif
    end
    reset = 0; start = 0; pause = 0; abort = 1; step(); abort = 0;
  endtask

`ifdef TIMER_WARN_EN
  task automatic test_warn();
    int j;
    bit fin;
    j = 0; fin = 0;
    load_val = 12'h005; start = 1; step(); start = 0;
    total++;
    if (low_time !== 1'b0) begin
      bad++; $display("FAIL warn_005 got=%b want=0", low_time);
    end
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (digits == 12'h005 || digits == 12'h004) begin
        total++;
        if (low_time !== 1'b0) begin bad++; $display("FAIL warn_high k=%0d got=%b want=0", k, low_time); end
      end else if (digits == 12'h003) begin
        total++;
        if (low_time !== ((j / 2) % 2 == 0)) begin
          bad++; $display("FAIL warn_blink j=%0d got=%b want=%b", j, low_time, (j / 2) % 2 == 0);
        end
        j++;
      end
      if (done === 1'b1) begin
        fin = 1;
        total++;
        if (low_time !== 1'b0) begin bad++; $display("FAIL warn_done got=%b want=0", low_time); end
      end
    end
    if (!fin) begin
      total++; bad++; $display("FAIL warn_timeout got=no_done want=done");
    end
    abort = 1; step(); abort = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_expire();
    test_pause();
    test_abort_start();
    test_reset_mid();
`ifdef TIMER_WARN_EN
    test_warn();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
